aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Parametrised AES round-control FSM; supersedes the fixed 10-round, decrypt-only controller.
//  Sequences key expansion, the initial AddRoundKey, NUM_ROUNDS-1 full rounds and one final round.
//  Supports AES-128/192/256 round counts and runtime encrypt/decrypt mode.
//  Drives the datapath state-register mux (SELECT), the column-wise MixColumns unit and the round-key index.
// PARAMETERS
//  NUM_ROUNDS     10  total rounds (10/12/14); legal range 2..15
//  KEYEXP_CYCLES  25  cycles spent in KEYEXP (1..63)
//  NUM_COLS       4   MixColumns passes per round, one column per cycle (1..4)
// PORTS
//  CLK            in   1   clock
//  RESET          in   1   synchronous, active-high reset
//  AES_START      in   1   level request; sampled only in WAIT
//  AES_DECRYPT    in   1   1=decrypt, 0=encrypt; latched on the cycle START is accepted
//  AES_DONE       out  1   high in DONE; held until AES_START is low
//  BUSY           out  1   high in every state except WAIT and DONE
//  SELECT         out  2   state-reg source: 00 (Inv)ShiftRows, 01 (Inv)SubBytes, 10 ARK, 11 (Inv)MixCols
//  Load_Reg       out  1   state-register load strobe
//  Load_MC        out  1   MixColumns column-latch strobe
//  COL_SEL        out  2   column for the current MIX cycle
//  KEY_IDX        out  4   round-key index: round (encrypt) or NUM_ROUNDS-round (decrypt)
//  Key_Run        out  1   key expansion enable; high throughout KEYEXP
// BEHAVIOUR
//  - Reset: state=WAIT, all counters 0, mode=0. All outputs 0, except KEY_IDX=0 and COL_SEL=0.
//  - RESET wins in any state, including mid-operation. The next cycle is WAIT with outputs at reset values.
//  - States: WAIT, KEYEXP, ARK0, SHIFT, SUB, ARK, MIX, MIX_WB, DONE.
//  - WAIT -> KEYEXP when AES_START=1. In the same edge, mode<=AES_DECRYPT and round<=0.
//  - KEYEXP: Key_Run=1; key count increments each cycle. Exit to ARK0 when count==KEYEXP_CYCLES-1.
//  - ARK0: SELECT=10, Load_Reg=1, round<=1 on exit.
//  - Decrypt round order: SHIFT -> SUB -> ARK -> MIX -> MIX_WB.
//  - Encrypt round order: SUB -> SHIFT -> MIX -> MIX_WB -> ARK.
//  - SHIFT/SUB/ARK states: one cycle each, Load_Reg=1, SELECT per the encoding above.
//  - MIX: stays NUM_COLS cycles. Load_MC=1, SELECT=11, COL_SEL=col; col wraps to 0 on exit.
//  - MIX_WB: Load_Reg=1, SELECT=11 (writes the assembled columns).
//  - Round end: round increments. If the new round==NUM_ROUNDS, the next round is final.
//  - Final round omits MIX/MIX_WB (decrypt SHIFT->SUB->ARK; encrypt SUB->SHIFT->ARK), then DONE.
//  - DONE -> WAIT when AES_START=0. A START held high never restarts the sequence.
//  - Latency: AES_DONE rises exactly 2+KEYEXP_CYCLES+(NUM_ROUNDS-1)*(4+NUM_COLS)+3 edges
//    after the edge that accepts START. Defaults: 102.
//  - Mode changes on AES_DECRYPT mid-run are ignored; only the latched mode is used.
//  - Default branch: go to WAIT; no latch inferred.
// CONFIGURATION
//  - AES_ABORT_EN defined: adds input AES_ABORT (1 bit).
//    When AES_ABORT=1 in any BUSY state: next state is WAIT, counters clear, AES_DONE is never raised.
//    When AES_ABORT=1 in WAIT or DONE: it has no effect.
//  - AES_ABORT_EN undefined: the port does not exist and the FSM is exactly as above.
// STRUCTURE
//  - Package aes_ctrl_pkg:
//    - state_t enum;
//    - SEL_SHIFT/SEL_SUB/SEL_ARK/SEL_MIX 2-bit localparams;
//    - function key_idx(round, mode, NUM_ROUNDS).
//  - Sub-module aes_step_counter #(W, MAX): sync clear, enable, terminal-count flag.
//    Three instances: key, column, round.
// TESTING
//  - Decrypt, defaults, START held:
//    - AES_DONE at edge 102;
//    - SELECT sequence begins 10,00,01,10,11x4(Load_MC),11(Load_Reg);
//    - KEY_IDX 10..0.
//  - Encrypt, NUM_ROUNDS=14, NUM_COLS=1:
//    - order SUB,SHIFT,MIX,MIX_WB,ARK;
//    - DONE at 2+25+13*5+3=95;
//    - KEY_IDX 0..14.
//  - RESET pulsed at cycle 50 of a run -> WAIT next cycle, BUSY=0, a new START gives the full 102 again.
//  - DONE held 10 cycles with START=1, then START=0 -> WAIT after one edge; START 0->1 restarts.
//  - AES_DECRYPT toggled every cycle during a run -> KEY_IDX follows the mode latched at start.
//  - AES_ABORT_EN: ABORT in MIX of round 3 -> WAIT, AES_DONE stays 0. ABORT in DONE -> ignored.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: state encoding, datapath mux selects and round-key index helper for the AES round sequencer
package aes_ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT, S_KEYEXP, S_ARK0, S_SHIFT, S_SUB, S_ARK, S_MIX, S_MIX_WB, S_DONE
    } state_t;

    localparam logic [1:0] SEL_SHIFT = 2'b00;
    localparam logic [1:0] SEL_SUB   = 2'b01;
    localparam logic [1:0] SEL_ARK   = 2'b10;
    localparam logic [1:0] SEL_MIX   = 2'b11;

    function automatic logic [3:0] key_idx(input logic [3:0] round, input logic mode, input logic [3:0] num_rounds);
        return mode ? num_rounds - round : round;
    endfunction

endpackage

// File: rtl/aes_step_counter.sv
// aes_step_counter: wrapping up-counter with sync clear, enable and terminal-count flag at MAX
module aes_step_counter #(
    parameter int W   = 4,
    parameter int MAX = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    assign tc = q == W'(MAX);

    always_ff @(posedge clk) begin
        if (clr) q <= '0;
        else if (en) q <= tc ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: parametrised AES round-control FSM (encrypt/decrypt); AES_ABORT_EN adds the AES_ABORT input
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS    = 10,
    parameter int KEYEXP_CYCLES = 25,
    parameter int NUM_COLS      = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    input  logic       AES_DECRYPT,
`ifdef AES_ABORT_EN
    input  logic       AES_ABORT,
`endif
    output logic       AES_DONE,
    output logic       BUSY,
    output logic [1:0] SELECT,
    output logic       Load_Reg,
    output logic       Load_MC,
    output logic [1:0] COL_SEL,
    output logic [3:0] KEY_IDX,
    output logic       Key_Run
);

    state_t     state, next;
    logic       mode, abort, accept, key_tc, col_tc, final_rnd, rnd_en;
    logic [5:0] unused_key_cnt;
    logic [3:0] round;

    assign accept = state == S_WAIT && AES_START;
    assign BUSY   = state != S_WAIT && state != S_DONE;
`ifdef AES_ABORT_EN
    assign abort  = AES_ABORT && BUSY;
`else
    assign abort  = 1'b0;
`endif

    // Round advances after ARK0, after MIX_WB when decrypting, after a non-final ARK when encrypting
    assign rnd_en = state == S_ARK0 || (state == S_MIX_WB && mode) || (state == S_ARK && !mode && !final_rnd);

    aes_step_counter #(.W(6), .MAX(KEYEXP_CYCLES - 1)) u_key (
        .clk(CLK), .clr(RESET || state != S_KEYEXP), .en(1'b1), .q(unused_key_cnt), .tc(key_tc)
    );

    aes_step_counter #(.W(2), .MAX(NUM_COLS - 1)) u_col (
        .clk(CLK), .clr(RESET || abort), .en(state == S_MIX), .q(COL_SEL), .tc(col_tc)
    );

    aes_step_counter #(.W(4), .MAX(NUM_ROUNDS)) u_round (
        .clk(CLK), .clr(RESET || abort || accept), .en(rnd_en), .q(round), .tc(final_rnd)
    );

    assign KEY_IDX = key_idx(round, mode, 4'(NUM_ROUNDS));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_WAIT;
            mode  <= 1'b0;
        end else begin
            state <= next;
            if (accept) mode <= AES_DECRYPT;
        end
    end

    always_comb begin
        next     = S_WAIT;
        SELECT   = SEL_SHIFT;
        Load_Reg = 1'b0;
        Load_MC  = 1'b0;
        Key_Run  = 1'b0;
        AES_DONE = 1'b0;
        case (state)
            S_WAIT:   next = AES_START ? S_KEYEXP : S_WAIT;
            S_KEYEXP: begin Key_Run = 1'b1; next = key_tc ? S_ARK0 : S_KEYEXP; end
            S_ARK0:   begin SELECT = SEL_ARK; Load_Reg = 1'b1; next = mode ? S_SHIFT : S_SUB; end
            S_SHIFT:  begin Load_Reg = 1'b1; next = mode ? S_SUB : (final_rnd ? S_ARK : S_MIX); end
            S_SUB:    begin SELECT = SEL_SUB; Load_Reg = 1'b1; next = mode ? S_ARK : S_SHIFT; end
            S_ARK:    begin SELECT = SEL_ARK; Load_Reg = 1'b1; next = final_rnd ? S_DONE : (mode ? S_MIX : S_SUB); end
            S_MIX:    begin SELECT = SEL_MIX; Load_MC = 1'b1; next = col_tc ? S_MIX_WB : S_MIX; end
            S_MIX_WB: begin SELECT = SEL_MIX; Load_Reg = 1'b1; next = mode ? S_SHIFT : S_ARK; end
            S_DONE:   begin AES_DONE = 1'b1; next = AES_START ? S_DONE : S_WAIT; end
            default:  next = S_WAIT;
        endcase
        if (abort) next = S_WAIT;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed self-checking bench for the default and 14-round/1-column sequencers
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, decrypt, start_b, decrypt_b;
    logic       done, busy, lr, lmc, kr, done_b, busy_b, lr_b, lmc_b, kr_b;
    logic [1:0] sel, col, sel_b, col_b;
    logic [3:0] kidx, kidx_b;
`ifdef AES_ABORT_EN
    logic       abort, abort_b;
`endif

    int checks = 0;
    int fails  = 0;
    logic [8:0] trace [0:255];
    logic [3:0] keys [$];

    wire [12:0] outs_a = {done, busy, sel, lr, lmc, col, kidx, kr};
    wire [12:0] outs_b = {done_b, busy_b, sel_b, lr_b, lmc_b, col_b, kidx_b, kr_b};

    aes_round_sequencer dut (
        .CLK(clk), .RESET(rst), .AES_START(start), .AES_DECRYPT(decrypt),
`ifdef AES_ABORT_EN
        .AES_ABORT(abort),
`endif
        .AES_DONE(done), .BUSY(busy), .SELECT(sel), .Load_Reg(lr), .Load_MC(lmc),
        .COL_SEL(col), .KEY_IDX(kidx), .Key_Run(kr)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14), .NUM_COLS(1)) dut_b (
        .CLK(clk), .RESET(rst), .AES_START(start_b), .AES_DECRYPT(decrypt_b),
`ifdef AES_ABORT_EN
        .AES_ABORT(abort_b),
`endif
        .AES_DONE(done_b), .BUSY(busy_b), .SELECT(sel_b), .Load_Reg(lr_b), .Load_MC(lmc_b),
        .COL_SEL(col_b), .KEY_IDX(kidx_b), .Key_Run(kr_b)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Edge 1 is the edge accepting START; trace[n] holds {done,busy,key_run,select,load_reg,load_mc,col_sel} after edge n
    task automatic collect(input bit b, input bit tog, input int limit, output int done_edge);
        logic [8:0] t;
        done_edge = -1;
        keys.delete();
        for (int n = 1; n <= limit && done_edge < 0; n++) begin
            step();
            t = b ? {done_b, busy_b, kr_b, sel_b, lr_b, lmc_b, col_b} : {done, busy, kr, sel, lr, lmc, col};
            trace[n] = t;
            if (t[5:4] == 2'b10 && t[3]) keys.push_back(b ? kidx_b : kidx);
            if (tog) decrypt = ~decrypt;
            if (t[8]) done_edge = n;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; start_b = 1'b0; decrypt_b = 1'b0;
`ifdef AES_ABORT_EN
        abort = 1'b0; abort_b = 1'b0;
`endif
        step(); step();
        checks++; if (outs_a !== 13'd0) begin fails++; $display("FAIL reset_a: got %b expected 0", outs_a); end
        checks++; if (outs_b !== 13'd0) begin fails++; $display("FAIL reset_b: got %b expected 0", outs_b); end
        rst = 1'b0;
        step();
        checks++; if (outs_a !== 13'd0) begin fails++; $display("FAIL idle_a: got %b expected 0", outs_a); end
    endtask

    task automatic test_decrypt;
        int de, krn, bn;
        logic [5:0] exp [0:8];
        exp = '{6'b10_1_0_00, 6'b00_1_0_00, 6'b01_1_0_00, 6'b10_1_0_00, 6'b11_0_1_00,
                6'b11_0_1_01, 6'b11_0_1_10, 6'b11_0_1_11, 6'b11_1_0_00};
        decrypt = 1'b1; start = 1'b1;
        collect(1'b0, 1'b0, 200, de);
        checks++; if (de !== 102) begin fails++; $display("FAIL dec_done_edge: got %0d expected 102", de); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (trace[26+i][5:0] !== exp[i]) begin
                fails++; $display("FAIL dec_seq[%0d]: got %b expected %b", i, trace[26+i][5:0], exp[i]);
            end
        end
        checks++; if (keys.size() != 11) begin fails++; $display("FAIL dec_key_count: got %0d expected 11", keys.size()); end
        for (int i = 0; i < keys.size() && i < 11; i++) begin
            checks++;
            if (keys[i] !== 4'(10 - i)) begin fails++; $display("FAIL dec_key[%0d]: got %0d expected %0d", i, keys[i], 10 - i); end
        end
        krn = 0; bn = 0;
        for (int n = 1; n <= de; n++) begin krn += int'(trace[n][6]); bn += int'(trace[n][7]); end
        checks++; if (krn != 25) begin fails++; $display("FAIL dec_key_run: got %0d expected 25", krn); end
        checks++; if (bn != 101) begin fails++; $display("FAIL dec_busy: got %0d expected 101", bn); end
    endtask

    task automatic test_done_hold;
        int dn = 0;
        for (int i = 0; i < 10; i++) begin step(); dn += int'(done); end
        checks++; if (dn != 10) begin fails++; $display("FAIL done_hold: got %0d expected 10", dn); end
        start = 1'b0;
        step();
        checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL done_release: got %b expected 00", {done, busy}); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL wait_idle: got %b expected 00", {done, busy}); end
        start = 1'b1;
        step();
        checks++; if ({busy, kr} !== 2'b11) begin fails++; $display("FAIL restart: got %b expected 11", {busy, kr}); end
    endtask

    task automatic test_reset_mid;
        int de;
        for (int i = 0; i < 48; i++) step();
        rst = 1'b1; start = 1'b0;
        step();
        checks++; if (outs_a !== 13'd0) begin fails++; $display("FAIL mid_reset: got %b expected 0", outs_a); end
        rst = 1'b0; decrypt = 1'b1; start = 1'b1;
        collect(1'b0, 1'b0, 200, de);
        checks++; if (de !== 102) begin fails++; $display("FAIL mid_reset_rerun: got %0d expected 102", de); end
        checks++; if (keys.size() == 0 || keys[0] !== 4'd10) begin fails++; $display("FAIL mid_reset_key0: got %0d expected 10", keys.size() ? keys[0] : 4'd0); end
        start = 1'b0;
        step();
    endtask

    task automatic test_encrypt;
        int de;
        logic [5:0] exp [0:8];
        exp = '{6'b10_1_0_00, 6'b01_1_0_00, 6'b00_1_0_00, 6'b11_0_1_00, 6'b11_1_0_00,
                6'b10_1_0_00, 6'b01_1_0_00, 6'b00_1_0_00, 6'b10_1_0_00};
        decrypt_b = 1'b0; start_b = 1'b1;
        collect(1'b1, 1'b0, 200, de);
        checks++; if (de !== 95) begin fails++; $display("FAIL enc_done_edge: got %0d expected 95", de); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (trace[i < 6 ? 26 + i : 86 + i][5:0] !== exp[i]) begin
                fails++; $display("FAIL enc_seq[%0d]: got %b expected %b", i, trace[i < 6 ? 26 + i : 86 + i][5:0], exp[i]);
            end
        end
        checks++; if (keys.size() != 15) begin fails++; $display("FAIL enc_key_count: got %0d expected 15", keys.size()); end
        for (int i = 0; i < keys.size() && i < 15; i++) begin
            checks++;
            if (keys[i] !== 4'(i)) begin fails++; $display("FAIL enc_key[%0d]: got %0d expected %0d", i, keys[i], i); end
        end
        start_b = 1'b0;
        step();
    endtask

    task automatic test_mode_toggle;
        int de;
        for (int m = 0; m < 2; m++) begin
            decrypt = m[0]; start = 1'b1;
            collect(1'b0, 1'b1, 200, de);
            checks++; if (de !== 102) begin fails++; $display("FAIL tog_done_edge[%0d]: got %0d expected 102", m, de); end
            checks++; if (keys.size() != 11) begin fails++; $display("FAIL tog_key_count[%0d]: got %0d expected 11", m, keys.size()); end
            for (int i = 0; i < keys.size() && i < 11; i++) begin
                checks++;
                if (keys[i] !== 4'(m ? 10 - i : i)) begin
                    fails++; $display("FAIL tog_key[%0d][%0d]: got %0d expected %0d", m, i, keys[i], m ? 10 - i : i);
                end
            end
            start = 1'b0;
            step();
        end
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort;
        int de, dn;
        decrypt = 1'b1; start = 1'b1;
        for (int i = 0; i < 46; i++) step();
        checks++; if ({sel, lmc, kidx} !== 7'b11_1_0111) begin fails++; $display("FAIL abort_pos: got %b expected 1110111", {sel, lmc, kidx}); end
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        checks++; if ({done, busy, sel, lr, lmc} !== 6'd0) begin fails++; $display("FAIL abort_wait: got %b expected 0", {done, busy, sel, lr, lmc}); end
        dn = 0;
        for (int i = 0; i < 120; i++) begin step(); dn += int'(done); end
        checks++; if (dn != 0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", dn); end
        start = 1'b1;
        collect(1'b0, 1'b0, 200, de);
        checks++; if (de !== 102) begin fails++; $display("FAIL abort_rerun: got %0d expected 102", de); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL abort_in_done: got %b expected 1", done); end
        start = 1'b0;
        step();
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done_release: got %b expected 0", done); end
    endtask
`endif

    initial begin
        test_reset();
        test_decrypt();
        test_done_hold();
        test_reset_mid();
        test_encrypt();
        test_mode_toggle();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
